frame_tx_stuffer: RTL and testbench
===================================

// Module: frame_tx_stuffer
// PURPOSE
//  Serial frame transmitter feeding the "100" delimiter-detector FSM on the receive side.
//  Accepts a parallel word over a valid/ready handshake and emits preamble "100" on out.
//  The word follows MSB-first, with bit stuffing so the sequence "100" never occurs inside a payload.
//  The line idles at 1. The delimiter fires only on the preamble.
// PARAMETERS
//  WIDTH  8  payload bits per frame (>=2)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  data_in     in   WIDTH  payload word, sampled on accept
//  data_valid  in   1      payload word available
//  data_ready  out  1      block can accept; = (state==IDLE)
//  out         out  1      serial line, registered
//  busy        out  1      1 while a frame is in flight (state!=IDLE)
//  frame_done  out  1      1-cycle pulse in the cycle the last frame bit is on out
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, out=1, busy=0, frame_done=0, data_ready=1.
//  Reset mid-frame aborts the frame immediately; the word is discarded; out returns to 1.
//  Accept: data_valid & data_ready at a rising edge latches data_in into the shift register.
//  FSM states: IDLE -> PRE (3 bits: 1,0,0) -> DATA <-> STUFF -> [PAR] -> IDLE.
//  - IDLE: out=1.
//  - PRE: one bit per cycle. The first preamble bit is on out in the cycle after the accept edge.
//  - DATA: WIDTH bits, MSB first, one per cycle.
//  - STUFF: one inserted '1', then back to DATA.
//  Stuff rule: 2-bit history of transmitted payload bits, including stuffed bits.
//  - The history is cleared to 00 at the start of DATA, so preamble bits never trigger stuffing.
//  - If the history is "10" and more payload/parity bits remain, insert a '1' before the next bit.
//  - No stuff bit after the final frame bit; the idle '1' already covers it.
//  Frame length = 3 + WIDTH + stuff_count (+1 with parity) cycles.
//  frame_done is asserted together with the final bit.
//  The next cycle returns to IDLE (out=1), so there is at least one idle '1' between frames.
//  data_ready=0 throughout PRE/DATA/STUFF/PAR.
//  data_valid held high is accepted on the first IDLE cycle edge.
//  data_valid without data_ready is ignored; no buffering.
//  data_in changes while busy have no effect.
//  Stuff counter width: clog2(WIDTH+1). Bit counter width: clog2(WIDTH+1).
//  Neither counter wraps within a frame; both clear in IDLE.
// CONFIGURATION
//  FRAME_TX_PARITY_EN defined:
//  - After the last data bit, state PAR sends one even-parity bit (XOR of the WIDTH data bits).
//  - Stuff bits are excluded from the parity.
//  - The stuff rule applies before the parity bit; no stuff after it.
//  - frame_done is asserted on the parity bit.
//  Not defined: PAR state absent; the frame ends on data bit 0.
// TESTING
//  T1 WIDTH=8, parity off, send 8'hA5.
//     -> out after accept: 1,0,0 then 1,0,1,1,0,1,0,1,1,0,1,1.
//     -> 15 cycles; frame_done on the 15th; then out=1.
//  T2 8'h00 -> out: 1,0,0 then eight 0s, no stuffing, 11 cycles.
//     8'hFF -> 1,0,0 then eight 1s, 11 cycles.
//  T3 data_valid held high with 8'hA5, then 8'h0F.
//     -> data_ready low for 15 cycles; >=1 idle '1' between frames.
//     -> second frame: 1,0,0,0,0,0,0,1,1,1,1.
//  T4 assert rst asynchronously in the 6th cycle of an 8'hA5 frame.
//     -> out=1, busy=0, data_ready=1 immediately, without waiting for a clock edge; no frame_done.
//     -> the next accepted frame is complete and correct.
//  T5 FRAME_TX_PARITY_EN, 8'hA5 -> T1 stream + parity 0, 16 cycles.
//     8'h01 -> 1,0,0, 0000000,1, parity 1, 12 cycles.
//  T6 scoreboard: random words through a reference "100" detector.
//     -> exactly one detection per frame (at the 3rd preamble bit); destuffed payload matches data_in.

Source files
------------

// File: rtl/frame_tx_stuffer.sv
// Serial frame transmitter: "100" preamble, then an MSB-first payload with bit stuffing so "100" never appears after the preamble.
// Optional even-parity bit after the payload when FRAME_TX_PARITY_EN is defined.
module frame_tx_stuffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    STUFF
`ifdef FRAME_TX_PARITY_EN
    , PAR
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    stuff_cnt;
  logic [1:0]       pre_cnt;
  logic [1:0]       hist;
`ifdef FRAME_TX_PARITY_EN
  logic             par_bit;
`endif

  assign data_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Each branch decides the bit that will be on 'out' during the next cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload register is reset too; it is tiny and keeps an aborted word from lingering.
      state      <= IDLE;
      out        <= 1'b1;
      frame_done <= 1'b0;
      sreg       <= '0;
      bit_cnt    <= '0;
      stuff_cnt  <= '0;
      pre_cnt    <= '0;
      hist       <= '0;
`ifdef FRAME_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else if (state == IDLE) begin
      // History clears here, so the first payload bit always starts from "00".
      out        <= 1'b1;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      stuff_cnt  <= '0;
      pre_cnt    <= '0;
      hist       <= '0;
      if (data_valid) begin
        sreg    <= data_in;
        state   <= PRE;
        pre_cnt <= 2'd1;
`ifdef FRAME_TX_PARITY_EN
        par_bit <= ^data_in;
`endif
      end
    end else if (frame_done) begin
      state      <= IDLE;
      out        <= 1'b1;
      frame_done <= 1'b0;
    end else if (state == PRE && pre_cnt != 2'd3) begin
      out     <= 1'b0;
      pre_cnt <= pre_cnt + 2'd1;
    end else if (hist == 2'b10 && stuff_cnt != '1) begin
      // A '0' after a '1' would let a following '0' form the delimiter.
      out       <= 1'b1;
      state     <= STUFF;
      hist      <= {hist[0], 1'b1};
      stuff_cnt <= stuff_cnt + CW'(1);
    end else if (bit_cnt != CW'(WIDTH)) begin
      out     <= sreg[WIDTH-1];
      sreg    <= {sreg[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt + CW'(1);
      hist    <= {hist[0], sreg[WIDTH-1]};
      state   <= DATA;
`ifdef FRAME_TX_PARITY_EN
      frame_done <= 1'b0;
`else
      frame_done <= (bit_cnt == CW'(WIDTH - 1));
`endif
    end
`ifdef FRAME_TX_PARITY_EN
    else begin
      out        <= par_bit;
      state      <= PAR;
      frame_done <= 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_frame_tx_stuffer.sv
// Directed bench for frame_tx_stuffer: hand-computed bit streams, handshake, async abort and a "100" detector/destuffer.
// Expectations follow FRAME_TX_PARITY_EN when the bench is compiled with it.
module tb_frame_tx_stuffer;

  localparam int WIDTH = 8;
`ifdef FRAME_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             out;
  logic             busy;
  logic             frame_done;

  int tests = 0;
  int fails = 0;

  frame_tx_stuffer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .out        (out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; the accept happens on the following posedge.
  task automatic run_frame(input string tag, input logic [WIDTH-1:0] word, input bit hold,
                           input bit check_stream, input int exp_len, input logic [63:0] exp_bits,
                           output int ready_low);
    logic [63:0]      cap = '0;
    logic             b [64];
    int               len = 0;
    bit               done = 1'b0;
    logic [2:0]       win = 3'b111;
    int               det_cnt = 0;
    int               det_pos = -1;
    logic [1:0]       h = 2'b00;
    logic [WIDTH-1:0] d = '0;
    int               nd = 0;
    logic             pbit = 1'b0;
    logic             gotp = 1'b0;
    int               bad_stuff = 0;
    data_in    = word;
    data_valid = 1'b1;
    ready_low  = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (i == 0 && !hold) begin
        data_valid = 1'b0;
        data_in    = ~word;
      end
      if (!data_ready) ready_low++;
      b[len] = out;
      cap    = {cap[62:0], out};
      len++;
      win = {win[1:0], out};
      if (win == 3'b100) begin
        det_cnt++;
        if (det_pos < 0) det_pos = len - 1;
      end
      done = frame_done;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    if (check_stream) begin
      check({tag, "_len"}, 64'(len), 64'(exp_len));
      check({tag, "_bits"}, cap, exp_bits);
    end
    check({tag, "_det_cnt"}, 64'(det_cnt), 64'd1);
    check({tag, "_det_pos"}, 64'(det_pos), 64'd2);
    for (int k = 3; k < len; k++) begin
      if (h == 2'b10) begin
        if (b[k] !== 1'b1) bad_stuff++;
        h = {h[0], 1'b1};
      end else begin
        if (nd < WIDTH) begin
          d = {d[WIDTH-2:0], b[k]};
          nd++;
        end else begin
          pbit = b[k];
          gotp = 1'b1;
        end
        h = {h[0], b[k]};
      end
    end
    check({tag, "_destuff"}, 64'(d), 64'(word));
    check({tag, "_nd"}, 64'(nd), 64'(WIDTH));
    check({tag, "_stuffbits"}, 64'(bad_stuff), 64'd0);
    check({tag, "_parity"}, 64'({gotp, pbit}), PAR_EN ? 64'({1'b1, ^word}) : 64'd0);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle_out"}, 64'(out), 64'd1);
    check({tag, "_idle_rdy"}, 64'(data_ready), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_fd"}, 64'(frame_done), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  word;
    int          len_np;
    logic [63:0] bits_np;
    int          len_p;
    logic [63:0] bits_p;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int rl;
    logic fd_seen;
    vecs[0] = '{8'hA5, 15, 64'b100101101011011,   16, 64'b1001011010110110};
    vecs[1] = '{8'h00, 11, 64'b10000000000,       12, 64'b100000000000};
    vecs[2] = '{8'hFF, 11, 64'b10011111111,       12, 64'b100111111110};
    vecs[3] = '{8'h0F, 11, 64'b10000001111,       12, 64'b100000011110};
    vecs[4] = '{8'h01, 11, 64'b10000000001,       12, 64'b100000000011};
    vecs[5] = '{8'h80, 17, 64'b10010101010101010, 19, 64'b1001010101010101011};

    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    repeat (2) @(negedge clk);
    check("rst_out", 64'(out), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdy", 64'(data_ready), 64'd1);
    check("rst_fd", 64'(frame_done), 64'd0);
    rst = 1'b0;
    idle_check("post_rst");

    // Directed frames (T1, T2, T5 and a worst-case stuffing word).
    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0h", vecs[i].word), vecs[i].word, 1'b0, 1'b1,
                PAR_EN ? vecs[i].len_p : vecs[i].len_np,
                PAR_EN ? vecs[i].bits_p : vecs[i].bits_np, rl);
      idle_check($sformatf("vec%0h", vecs[i].word));
    end

    // Back-to-back with data_valid held high.
    run_frame("t3a", 8'hA5, 1'b1, 1'b1, PAR_EN ? 16 : 15,
              PAR_EN ? vecs[0].bits_p : vecs[0].bits_np, rl);
    check("t3a_ready_low", 64'(rl), PAR_EN ? 64'd16 : 64'd15);
    data_in = 8'h0F;
    @(negedge clk);
    check("t3_gap_out", 64'(out), 64'd1);
    check("t3_gap_rdy", 64'(data_ready), 64'd1);
    run_frame("t3b", 8'h0F, 1'b0, 1'b1, PAR_EN ? 12 : 11,
              PAR_EN ? vecs[3].bits_p : vecs[3].bits_np, rl);
    idle_check("t3b");

    // Async abort in the 6th frame cycle.
    data_in    = 8'hA5;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_mid_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_out", 64'(out), 64'd1);
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_rdy", 64'(data_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    fd_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      fd_seen = fd_seen | frame_done;
    end
    check("t4_no_fd", 64'(fd_seen), 64'd0);
    run_frame("t4_next", 8'hA5, 1'b0, 1'b1, PAR_EN ? 16 : 15,
              PAR_EN ? vecs[0].bits_p : vecs[0].bits_np, rl);
    idle_check("t4_next");

    // Random words: delimiter detector and destuffer only.
    for (int n = 0; n < 6; n++) begin
      run_frame($sformatf("rnd%0d", n), 8'($urandom), 1'b0, 1'b0, 0, '0, rl);
      idle_check($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
